// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences the CPU reset pulse and gates execution until halt, PC self-loop or cycle budget
module cpu_run_ctrl #(
    parameter int RST_HOLD_CYCLES = 1,
    parameter int MAX_CYCLES      = 50,
    parameter int HALT_STABLE     = 2,
    parameter int PC_W            = 32,
    parameter int CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_halt,
    input  logic [PC_W-1:0]  i_pc,
    output logic             o_cpu_rst,
    output logic             o_cpu_en,
    output logic             o_running,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycles,
    output logic [PC_W-1:0]  o_final_pc
);
    localparam int HOLD_W  = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int STALL_W = $clog2(HALT_STABLE + 1) + 1;

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [HOLD_W-1:0]  hold;
    logic [STALL_W-1:0] stall, stall_nxt;
    logic [PC_W-1:0]    prev_pc;
    logic               first;
    logic [CNT_W-1:0]   cycles_nxt;
    logic               by_halt, by_stall, by_budget, launch, finish;

    assign o_cpu_rst = (state == IDLE) || (state == RESET);
    assign o_cpu_en  = state == RUN;
    assign o_running = (state == RESET) || (state == RUN);
    assign o_done    = state == DONE;

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next state plus the three termination conditions of a RUN cycle
    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        finish     = 1'b0;
        stall_nxt  = (!first && i_pc == prev_pc) ? stall + 1'b1 : '0;
        cycles_nxt = &o_cycles ? o_cycles : o_cycles + 1'b1;
        by_halt    = i_halt;
        by_stall   = stall_nxt == STALL_W'(HALT_STABLE);
        by_budget  = (MAX_CYCLES != 0) && (cycles_nxt == CNT_W'(MAX_CYCLES));
        case (state)
            IDLE, DONE: if (i_start) begin
                state_nxt = RESET;
                launch    = 1'b1;
            end
            RESET: if (hold == '0) state_nxt = RUN;
            RUN: if (by_halt || by_stall || by_budget) begin
                state_nxt = DONE;
                finish    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // hold/stall bookkeeping and registered status; halt or stall wins over timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold       <= '0;
            stall      <= '0;
            prev_pc    <= '0;
            first      <= 1'b0;
            o_timeout  <= 1'b0;
            o_cycles   <= '0;
            o_final_pc <= '0;
        end else if (launch) begin
            hold       <= HOLD_W'(RST_HOLD_CYCLES - 1);
            o_timeout  <= 1'b0;
            o_cycles   <= '0;
            o_final_pc <= '0;
        end else if (state == RESET) begin
            hold  <= hold - 1'b1;
            stall <= '0;
            first <= 1'b1;
        end else if (state == RUN) begin
            o_cycles <= cycles_nxt;
            prev_pc  <= i_pc;
            stall    <= stall_nxt;
            first    <= 1'b0;
            if (finish) begin
                o_final_pc <= i_pc;
                o_timeout  <= by_budget && !by_halt && !by_stall;
            end
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized and directed runs checked against a run-level reference model
module tb_cpu_run_ctrl;
    localparam int HOLD = 3;
    localparam int MAXC = 10;
    localparam int HS   = 2;

    logic        clk = 0, rst_n = 0, start = 0, halt = 0;
    logic [15:0] pc = '0;
    logic        o_cpu_rst, o_cpu_en, o_running, o_done, o_timeout;
    logic [7:0]  o_cycles;
    logic [15:0] o_final_pc;

    logic [15:0] pc_t [1:MAXC];
    bit          halt_t [1:MAXC];
    int          checks = 0, errors = 0;

    cpu_run_ctrl #(.RST_HOLD_CYCLES(HOLD), .MAX_CYCLES(MAXC), .HALT_STABLE(HS), .PC_W(16), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_halt(halt), .i_pc(pc),
        .o_cpu_rst(o_cpu_rst), .o_cpu_en(o_cpu_en), .o_running(o_running), .o_done(o_done),
        .o_timeout(o_timeout), .o_cycles(o_cycles), .o_final_pc(o_final_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Run ends at the first cycle with halt, or whose PC equals the HS previous in-run PCs, else at the budget
    task automatic model(output int end_n, output bit to);
        end_n = MAXC;
        to = 1;
        for (int n = 1; n <= MAXC; n++) begin
            bit same;
            same = n > HS;
            for (int j = n - HS; j < n; j++)
                if (j >= 1 && pc_t[j] != pc_t[n]) same = 0;
            if (halt_t[n] || same) begin
                end_n = n;
                to = 0;
                return;
            end
        end
    endtask

    task automatic fill(input int kind);
        for (int n = 1; n <= MAXC; n++) begin
            pc_t[n]   = 16'(4 * (n - 1));
            halt_t[n] = 0;
        end
        case (kind)
            1: halt_t[7] = 1;
            2: halt_t[MAXC] = 1;
            3: begin
                pc_t[4] = 8; pc_t[5] = 8;
                for (int n = 6; n <= MAXC; n++) pc_t[n] = 16'(4 * n);
            end
            4: begin
                pc_t[1] = 8; pc_t[2] = 8; pc_t[3] = 4;
                for (int n = 4; n <= MAXC; n++) pc_t[n] = 16'(4 * n);
            end
            5: for (int n = 1; n <= MAXC; n++) begin
                pc_t[n]   = (n == 1) ? 16'(4 * $urandom_range(0, 3))
                          : ($urandom_range(0, 2) == 0 ? pc_t[n-1] : pc_t[n-1] + 16'd4);
                halt_t[n] = $urandom_range(0, 11) == 0;
            end
            default: ;
        endcase
    endtask

    task automatic flags(input string tag, input logic [3:0] exp);
        check(tag, {o_cpu_rst, o_cpu_en, o_running, o_done}, exp);
    endtask

    task automatic run(input int abort_at);
        int end_n;
        bit to;
        model(end_n, to);
        @(negedge clk);
        start = 1;
        @(posedge clk);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            flags("rst_flags", 4'b1010);
            check("rst_cycles", o_cycles, 0);
            check("rst_timeout", o_timeout, 0);
            check("rst_final_pc", o_final_pc, 0);
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        for (int n = 1; n <= end_n; n++) begin
            @(negedge clk);
            flags("run_flags", 4'b0110);
            check("run_cycles", o_cycles, n - 1);
            pc    = pc_t[n];
            halt  = halt_t[n];
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (n == abort_at) begin
                #2 rst_n = 0;
                #1;
                flags("abort_flags", 4'b1000);
                check("abort_cycles", o_cycles, 0);
                check("abort_timeout", o_timeout, 0);
                check("abort_final_pc", o_final_pc, 0);
                @(negedge clk);
                rst_n = 1;
                start = 0;
                halt  = 0;
                return;
            end
        end
        @(negedge clk);
        start = 0;
        halt  = 0;
        for (int i = 0; i < 3; i++) begin
            flags("done_flags", 4'b0001);
            check("done_cycles", o_cycles, end_n);
            check("done_timeout", o_timeout, to);
            check("done_final_pc", o_final_pc, pc_t[end_n]);
            pc   = 16'($urandom);
            halt = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        halt = 0;
    endtask

    initial begin
        #3;
        flags("reset_flags", 4'b1000);
        check("reset_cycles", o_cycles, 0);
        check("reset_timeout", o_timeout, 0);
        check("reset_final_pc", o_final_pc, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            flags("idle_flags", 4'b1000);
        end
        for (int k = 0; k <= 4; k++) begin
            fill(k);
            run(0);
        end
        fill(0);
        run(5);
        fill(0);
        run(0);
        repeat (20) begin
            fill(5);
            run(0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller that sits between the top level and `cpu`. It sequences the CPU's reset pulse and gates its execution with a clock enable. Each run ends on an explicit halt, a PC self-loop, or a cycle budget. It reports a done/timeout status, the cycle count and the final PC. It replaces the fixed "pulse reset, run N cycles" bench sequence with a parametrised, on-chip mechanism usable in both simulation and hardware.

## Interface
- `RST_HOLD_CYCLES`, default 1: cycles `o_cpu_rst` is held high in RESET; must be ≥ 1.
- `MAX_CYCLES`, default 50: RUN-cycle budget. 0 means no limit.
- `HALT_STABLE`, default 2: consecutive unchanged-PC cycles that count as a self-loop halt; must be ≥ 1.
- `PC_W`, default 32: PC width.
- `CNT_W`, default 16: cycle counter width; must satisfy 2^CNT_W − 1 ≥ MAX_CYCLES.

Ports (name, direction, width, meaning):
- `i_clk`  in  1  single clock for the block and the CPU.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  run request; sampled in IDLE and DONE only.
- `i_halt`  in  1  explicit halt from the datapath.
- `i_pc`  in  PC_W  current CPU program counter.
- `o_cpu_rst`  out  1  active-high reset to `cpu.i_rst`.
- `o_cpu_en`  out  1  CPU clock enable; high only in RUN.
- `o_running`  out  1  high in RESET and RUN.
- `o_done`  out  1  high in DONE.
- `o_timeout`  out  1  the run ended on the cycle budget.
- `o_cycles`  out  CNT_W  RUN cycles executed in the current or last run.
- `o_final_pc`  out  PC_W  PC captured when the run ended.

## Operation
- Reset (`i_rst_n` = 0, asynchronous): state IDLE; `o_cpu_rst`=1; all other outputs 0; internal hold, stall and previous-PC registers 0.
- States: IDLE, RESET, RUN, DONE. All outputs are registered or decoded from state only (Moore).
- IDLE: `o_cpu_rst`=1, `o_cpu_en`=0.
  - `i_start`=1 → RESET. Clear `o_cycles`, `o_timeout`, `o_final_pc`; load the hold counter.
- RESET: `o_cpu_rst`=1, `o_cpu_en`=0.
  - After exactly RST_HOLD_CYCLES cycles in RESET → RUN.
  - Clear the stall counter and mark the next cycle as the first RUN cycle.
- RUN: `o_cpu_rst`=0, `o_cpu_en`=1.
  - Each cycle: `o_cycles` += 1, saturating at all-ones; previous-PC register ← `i_pc`.
  - Stall counter: increments when `i_pc` == previous PC and this is not the first RUN cycle; otherwise resets to 0.
  - Terminate → DONE with `o_final_pc` ← `i_pc` of the terminating cycle when any of these holds:
    - (a) `i_halt`=1;
    - (b) stall counter reaches HALT_STABLE;
    - (c) MAX_CYCLES≠0 and this is RUN cycle number MAX_CYCLES.
  - `o_timeout` ← 1 only if (c) holds and neither (a) nor (b) does. Halt or stall wins over timeout on the same cycle.
- DONE: `o_cpu_rst`=0, `o_cpu_en`=0. The CPU is frozen with its state preserved for inspection.
  - Status outputs are held.
  - `i_start`=1 → RESET, with the same clears as from IDLE.
- `i_start` is ignored in RESET and RUN.
- An `i_rst_n` assertion mid-run aborts immediately to IDLE. The CPU is put back into reset and status is cleared.

## Timing
- `i_start` high at edge k → `o_cpu_rst`, `o_running` high after edge k.
  - `o_cpu_en` rises after edge k+RST_HOLD_CYCLES.
- The CPU executes exactly one instruction cycle per RUN cycle. The terminating cycle counts.
- Timeout: DONE is entered at the edge ending RUN cycle MAX_CYCLES. `o_cycles`=MAX_CYCLES and `o_cpu_en` falls at the same edge.
- Halt: `i_halt` high in RUN cycle n → DONE at the end of cycle n, with `o_cycles`=n.
- Stall: the PC is unchanged across HALT_STABLE+1 consecutive samples → DONE.
- `o_done` is high from the first DONE cycle until the next start or reset.

## Test plan
- Default params. Pulse `i_start`; the PC increments every cycle and never halts → `o_cpu_rst` high 1 cycle, RUN 50 cycles, `o_done`=1, `o_timeout`=1, `o_cycles`=50, `o_final_pc`=last PC.
- RST_HOLD_CYCLES=3. Assert `i_halt` in RUN cycle 7 → reset held exactly 3 cycles; `o_cycles`=7, `o_timeout`=0, `o_final_pc`=PC of cycle 7.
- PC sequence 0,4,8,8,8 with HALT_STABLE=2 → DONE after the 5th RUN cycle, `o_final_pc`=8, `o_timeout`=0. The sequence 8,8,4 instead resets the stall count and does not terminate.
- MAX_CYCLES=10 with `i_halt` asserted in cycle 10 → `o_timeout`=0, `o_cycles`=10.
- `i_start` pulses during RESET and RUN are ignored. After DONE, `i_start` restarts the run: `o_cycles` clears to 0 and `o_done` drops.
- Drop `i_rst_n` during RUN cycle 20 → all outputs return to reset values asynchronously and `o_cpu_rst`=1. A later `i_start` runs a clean sequence.
